parser_rule_loader: RTL and testbench

//  Sequences all rule configuration into the pipelined parser. Two requesters share one config path:
//  the host CSR port and the bulk loader stream. The block assembles multi-word type rules into

---
 rtl/parser_rule_loader_pkg.sv | 35 +++
 rtl/parser_rule_loader_rr_arb2.sv | 60 ++++++
 rtl/parser_rule_loader.sv | 270 +++++++++++++++++++++++++++
 tb/tb_parser_rule_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/parser_rule_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parser_rule_loader_pkg
// Description : Shared definitions for the parser rule loader: config word
//               addresses, loader FSM state encoding, requester ids and
//               helpers that size a rule in 32-bit words.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package parser_rule_loader_pkg;

   localparam logic [31:0] ADDR_TYPE_OFFSET = 32'd0;
   localparam logic [31:0] ADDR_RULE_WORD   = 32'd1;

   localparam logic REQ_HOST   = 1'b0;
   localparam logic REQ_LOADER = 1'b1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      COMMIT  = 2'd2
   } state_t;

   // Number of 32-bit words needed to carry all key extract offsets.
   function automatic int calc_kw(input int key_num, input int key_w);
      return (key_num * key_w + 31) / 32;
   endfunction

   // Words per rule: header word, one word per type field, then key words.
   function automatic int calc_nw(input int type_num, input int key_num, input int key_w);
      return 1 + type_num + calc_kw(key_num, key_w);
   endfunction

endpackage
`default_nettype wire

// File: rtl/parser_rule_loader_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. The pointer holds the id of the
//               requester served last; on a tie the other one wins. While
//               locked, only the owner can be granted.
// Ports       : i_clk, i_rst_n          clock / async active-low reset
//               i_req[1:0]              request vector (0=host, 1=loader)
//               i_lock, i_owner         restrict grant to the owner
//               i_update, i_update_id   load pointer with last-served id
//               o_gnt[1:0], o_gnt_id    one-hot grant and its id
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_req,
   input  logic       i_lock,
   input  logic       i_owner,
   input  logic       i_update,
   input  logic       i_update_id,
   output logic [1:0] o_gnt,
   output logic       o_gnt_id
);

   logic ptr_q;
   logic ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (i_update) begin
         ptr_d = i_update_id;
      end
   end

   always_comb begin
      if (i_lock) begin
         o_gnt_id = i_owner;
      end else if (i_req == 2'b11) begin
         o_gnt_id = ~ptr_q;
      end else begin
         o_gnt_id = i_req[1];
      end
      o_gnt = 2'b00;
      if (i_req[o_gnt_id]) begin
         o_gnt[o_gnt_id] = 1'b1;
      end
   end

   // Pointer resets to the loader so the host wins the first tie.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr_q <= 1'b1;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/parser_rule_loader.sv
`default_nettype none
// ============================================================================
// Module      : parser_rule_loader
// Description : Arbitrates host CSR and bulk loader config writes, assembles
//               multi-word type rules in staging registers and commits each
//               rule atomically to the Lookup_Type bank while the parser
//               pipeline is idle.
// Ports       : i_clk, i_rst_n                 clock / async active-low reset
//               i_host_*, o_host_ready         host word write handshake
//               i_ld_*, o_ld_ready             loader word write handshake
//               i_pipe_busy                    blocks commits / offset writes
//               i_err_clr                      clears sticky o_err
//               o_type_offset                  type-field extract offsets
//               o_typeRule_*                   committed rule + wren strobe
//               o_busy, o_err, o_commit_cnt    status
// Revision    : 1.0 - initial release
// ============================================================================
module parser_rule_loader
   import parser_rule_loader_pkg::*;
#(
   parameter int TYPE_NUM          = 2,
   parameter int TYPE_WIDTH        = 16,
   parameter int TYPE_OFFSET_WIDTH = 5,
   parameter int KEY_FIELD_NUM     = 8,
   parameter int KEY_OFFSET_WIDTH  = 6,
   parameter int RULE_NUM          = 4
) (
   input  logic                                      i_clk,
   input  logic                                      i_rst_n,
   input  logic                                      i_host_valid,
   output logic                                      o_host_ready,
   input  logic [31:0]                               i_host_addr,
   input  logic [31:0]                               i_host_wdata,
   input  logic                                      i_ld_valid,
   output logic                                      o_ld_ready,
   input  logic [31:0]                               i_ld_addr,
   input  logic [31:0]                               i_ld_wdata,
   input  logic                                      i_pipe_busy,
   input  logic                                      i_err_clr,
   output logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]     o_type_offset,
   output logic [RULE_NUM-1:0]                       o_typeRule_wren,
   output logic                                      o_typeRule_valid,
   output logic [TYPE_NUM*TYPE_WIDTH-1:0]            o_typeRule_typeData,
   output logic [TYPE_NUM*TYPE_WIDTH-1:0]            o_typeRule_typeMask,
   output logic [KEY_FIELD_NUM*KEY_OFFSET_WIDTH-1:0] o_typeRule_keyOffset,
   output logic                                      o_busy,
   output logic                                      o_err,
   output logic [15:0]                               o_commit_cnt
);

   localparam int KW    = calc_kw(KEY_FIELD_NUM, KEY_OFFSET_WIDTH);
   localparam int NW    = calc_nw(TYPE_NUM, KEY_FIELD_NUM, KEY_OFFSET_WIDTH);
   localparam int KOW   = KEY_FIELD_NUM * KEY_OFFSET_WIDTH;
   localparam int TOW   = TYPE_NUM * TYPE_OFFSET_WIDTH;
   localparam int TDW   = TYPE_NUM * TYPE_WIDTH;
   localparam int STG_W = (NW - 1) * 32;
   localparam int CW    = $clog2(NW);

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [15:0]       idx_q, idx_d;
   logic              stg_valid_q, stg_valid_d;
   logic [STG_W-1:0]  stage_q, stage_d;
   logic [TOW-1:0]    type_offset_q, type_offset_d;
   logic              rule_valid_q, rule_valid_d;
   logic [TDW-1:0]    type_data_q, type_data_d;
   logic [TDW-1:0]    type_mask_q, type_mask_d;
   logic [KOW-1:0]    key_off_q, key_off_d;
   logic [RULE_NUM-1:0] wren_q, wren_d;
   logic              err_q, err_d;
   logic [15:0]       commit_cnt_q, commit_cnt_d;

   logic [1:0]        w_gnt;
   logic              w_sel;
   logic              w_upd;
   logic              w_upd_id;
   logic [31:0]       w_addr;
   logic [31:0]       w_wdata;
   logic              w_blocked;
   logic              w_rdy;
   logic              w_accept;
   logic              w_new_err;
   logic              w_idx_ok;
   logic [TDW-1:0]    w_stg_data;
   logic [TDW-1:0]    w_stg_mask;
   logic [KOW-1:0]    w_stg_key;

   rr_arb2 u_arb (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_req       ({i_ld_valid, i_host_valid}),
      .i_lock      (state_q == COLLECT),
      .i_owner     (owner_q),
      .i_update    (w_upd),
      .i_update_id (w_upd_id),
      .o_gnt       (w_gnt),
      .o_gnt_id    (w_sel)
   );

   // While locked the arbiter reports the owner, so w_sel always names
   // the requester whose word is being considered.
   assign w_addr  = (w_sel == REQ_LOADER) ? i_ld_addr  : i_host_addr;
   assign w_wdata = (w_sel == REQ_LOADER) ? i_ld_wdata : i_host_wdata;

   // Offset writes reconfigure the live extractor, so hold them off while a
   // header is in flight.
   assign w_blocked = (state_q == IDLE) && (w_addr == ADDR_TYPE_OFFSET) && i_pipe_busy;
   assign w_rdy     = (state_q != COMMIT) && !w_blocked;

   assign o_host_ready = w_gnt[0] && w_rdy;
   assign o_ld_ready   = w_gnt[1] && w_rdy;
   assign w_accept     = (o_host_ready && i_host_valid) || (o_ld_ready && i_ld_valid);

   assign w_idx_ok = (idx_q < 16'(RULE_NUM));

   // Type word t carries data in [31:16] and mask in [15:0]; type 0 lands in
   // the most significant slot of the packed outputs.
   for (genvar t = 0; t < TYPE_NUM; t++) begin : g_type
      assign w_stg_data[(TYPE_NUM-1-t)*TYPE_WIDTH +: TYPE_WIDTH] = stage_q[t*32+16 +: TYPE_WIDTH];
      assign w_stg_mask[(TYPE_NUM-1-t)*TYPE_WIDTH +: TYPE_WIDTH] = stage_q[t*32 +: TYPE_WIDTH];
   end

   assign w_stg_key = stage_q[TYPE_NUM*32 +: KOW];

   // Padding bits in the final key word carry no information.
   if (KW * 32 > KOW) begin : g_key_pad
      logic w_unused_pad;
      assign w_unused_pad = ^stage_q[STG_W-1:TYPE_NUM*32+KOW];
   end

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      cnt_d         = cnt_q;
      idx_d         = idx_q;
      stg_valid_d   = stg_valid_q;
      stage_d       = stage_q;
      type_offset_d = type_offset_q;
      rule_valid_d  = rule_valid_q;
      type_data_d   = type_data_q;
      type_mask_d   = type_mask_q;
      key_off_d     = key_off_q;
      commit_cnt_d  = commit_cnt_q;
      wren_d        = '0;
      w_upd         = 1'b0;
      w_upd_id      = w_sel;
      w_new_err     = 1'b0;

      case (state_q)
         IDLE: begin
            if (w_accept) begin
               w_upd = 1'b1;
               if (w_addr == ADDR_TYPE_OFFSET) begin
                  type_offset_d = w_wdata[TOW-1:0];
               end else if (w_addr == ADDR_RULE_WORD) begin
                  idx_d       = w_wdata[15:0];
                  stg_valid_d = w_wdata[31];
                  owner_d     = w_sel;
                  cnt_d       = CW'(1);
                  state_d     = COLLECT;
               end else begin
                  w_new_err = 1'b1;
               end
            end
         end
         COLLECT: begin
            if (w_accept) begin
               if (w_addr == ADDR_RULE_WORD) begin
                  for (int w = 0; w < NW - 1; w++) begin
                     if (cnt_q == CW'(w + 1)) begin
                        stage_d[w*32 +: 32] = w_wdata;
                     end
                  end
                  if (cnt_q == CW'(NW - 1)) begin
                     state_d = COMMIT;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end else if (w_addr == ADDR_TYPE_OFFSET) begin
                  // Offset write mid-rule means the owner lost sync; drop the rule.
                  w_new_err = 1'b1;
                  state_d   = IDLE;
               end else begin
                  w_new_err = 1'b1;
               end
            end
         end
         COMMIT: begin
            if (!i_pipe_busy) begin
               state_d  = IDLE;
               w_upd    = 1'b1;
               w_upd_id = owner_q;
               if (w_idx_ok) begin
                  rule_valid_d = stg_valid_q;
                  type_data_d  = w_stg_data;
                  type_mask_d  = w_stg_mask;
                  key_off_d    = w_stg_key;
                  commit_cnt_d = commit_cnt_q + 16'd1;
                  for (int r = 0; r < RULE_NUM; r++) begin
                     if (idx_q == 16'(r)) begin
                        wren_d[r] = 1'b1;
                     end
                  end
               end else begin
                  w_new_err = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A new error outranks a simultaneous clear.
      err_d = err_q;
      if (i_err_clr) begin
         err_d = 1'b0;
      end
      if (w_new_err) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= IDLE;
         owner_q       <= REQ_HOST;
         cnt_q         <= '0;
         idx_q         <= '0;
         stg_valid_q   <= 1'b0;
         stage_q       <= '0;
         type_offset_q <= '0;
         rule_valid_q  <= 1'b0;
         type_data_q   <= '0;
         type_mask_q   <= '0;
         key_off_q     <= '0;
         wren_q        <= '0;
         err_q         <= 1'b0;
         commit_cnt_q  <= '0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         stg_valid_q   <= stg_valid_d;
         stage_q       <= stage_d;
         type_offset_q <= type_offset_d;
         rule_valid_q  <= rule_valid_d;
         type_data_q   <= type_data_d;
         type_mask_q   <= type_mask_d;
         key_off_q     <= key_off_d;
         wren_q        <= wren_d;
         err_q         <= err_d;
         commit_cnt_q  <= commit_cnt_d;
      end
   end

   assign o_type_offset        = type_offset_q;
   assign o_typeRule_wren      = wren_q;
   assign o_typeRule_valid     = rule_valid_q;
   assign o_typeRule_typeData  = type_data_q;
   assign o_typeRule_typeMask  = type_mask_q;
   assign o_typeRule_keyOffset = key_off_q;
   assign o_busy               = (state_q != IDLE);
   assign o_err                = err_q;
   assign o_commit_cnt         = commit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_parser_rule_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_parser_rule_loader
// Description : Self-checking bench for parser_rule_loader: a table of
//               per-cycle host vectors followed by hand-written sequences
//               for stalls, bad indices, error clearing, reset and
//               host/loader arbitration.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parser_rule_loader;

   logic        clk;
   logic        rst_n;
   logic        host_valid, host_ready;
   logic [31:0] host_addr, host_wdata;
   logic        ld_valid, ld_ready;
   logic [31:0] ld_addr, ld_wdata;
   logic        pipe_busy, err_clr;
   logic [9:0]  type_offset;
   logic [3:0]  wren;
   logic        rule_valid;
   logic [31:0] type_data, type_mask;
   logic [47:0] key_off;
   logic        busy, err;
   logic [15:0] commit_cnt;

   int n_vec;
   int n_err;

   parser_rule_loader dut (
      .i_clk                (clk),
      .i_rst_n              (rst_n),
      .i_host_valid         (host_valid),
      .o_host_ready         (host_ready),
      .i_host_addr          (host_addr),
      .i_host_wdata         (host_wdata),
      .i_ld_valid           (ld_valid),
      .o_ld_ready           (ld_ready),
      .i_ld_addr            (ld_addr),
      .i_ld_wdata           (ld_wdata),
      .i_pipe_busy          (pipe_busy),
      .i_err_clr            (err_clr),
      .o_type_offset        (type_offset),
      .o_typeRule_wren      (wren),
      .o_typeRule_valid     (rule_valid),
      .o_typeRule_typeData  (type_data),
      .o_typeRule_typeMask  (type_mask),
      .o_typeRule_keyOffset (key_off),
      .o_busy               (busy),
      .o_err                (err),
      .o_commit_cnt         (commit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        hv;
      logic [31:0] ha;
      logic [31:0] hd;
      logic        pb;
      logic        e_hr;
      logic [9:0]  e_toff;
      logic [3:0]  e_wren;
      logic [15:0] e_cnt;
      logic        e_busy;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 ns later.
   task automatic drive(input logic hv, input logic [31:0] ha, input logic [31:0] hd,
                        input logic lv, input logic [31:0] la, input logic [31:0] ld,
                        input logic pb, input logic clr);
      @(negedge clk);
      host_valid = hv; host_addr = ha; host_wdata = hd;
      ld_valid   = lv; ld_addr   = la; ld_wdata   = ld;
      pipe_busy  = pb; err_clr   = clr;
      #1;
   endtask

   task automatic hdrive(input logic hv, input logic [31:0] ha, input logic [31:0] hd,
                         input logic pb, input logic clr);
      drive(hv, ha, hd, 1'b0, 32'd0, 32'd0, pb, clr);
   endtask

   task automatic host_rule(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                            input logic [31:0] w3, input logic [31:0] w4);
      logic [31:0] w[5];
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3; w[4] = w4;
      for (int i = 0; i < 5; i++) begin
         hdrive(1'b1, 32'd1, w[i], 1'b0, 1'b0);
         chk("host_rule_ready", 64'(host_ready), 64'd1);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      host_valid = 1'b0; host_addr = '0; host_wdata = '0;
      ld_valid = 1'b0; ld_addr = '0; ld_wdata = '0;
      pipe_busy = 1'b0; err_clr = 1'b0;

      //                hv    addr   wdata          busy  hr    toff    wren  cnt    obusy
      tbl[0]  = '{1'b1, 32'd0, 32'h0000_0043, 1'b0, 1'b1, 10'h000, 4'h0, 16'd0, 1'b0};
      tbl[1]  = '{1'b0, 32'd0, 32'h0000_0000, 1'b0, 1'b0, 10'h043, 4'h0, 16'd0, 1'b0};
      tbl[2]  = '{1'b1, 32'd1, 32'h8000_0002, 1'b0, 1'b1, 10'h043, 4'h0, 16'd0, 1'b0};
      tbl[3]  = '{1'b1, 32'd1, 32'h0800_FFFF, 1'b0, 1'b1, 10'h043, 4'h0, 16'd0, 1'b1};
      tbl[4]  = '{1'b1, 32'd1, 32'h86DD_FFFF, 1'b0, 1'b1, 10'h043, 4'h0, 16'd0, 1'b1};
      tbl[5]  = '{1'b1, 32'd1, 32'h0403_0201, 1'b0, 1'b1, 10'h043, 4'h0, 16'd0, 1'b1};
      tbl[6]  = '{1'b1, 32'd1, 32'h0000_0605, 1'b0, 1'b1, 10'h043, 4'h0, 16'd0, 1'b1};
      tbl[7]  = '{1'b0, 32'd0, 32'h0000_0000, 1'b0, 1'b0, 10'h043, 4'h0, 16'd0, 1'b1};
      tbl[8]  = '{1'b0, 32'd0, 32'h0000_0000, 1'b0, 1'b0, 10'h043, 4'h4, 16'd1, 1'b0};
      tbl[9]  = '{1'b1, 32'd0, 32'h0000_0055, 1'b1, 1'b0, 10'h043, 4'h0, 16'd1, 1'b0};
      tbl[10] = '{1'b0, 32'd0, 32'h0000_0000, 1'b0, 1'b0, 10'h043, 4'h0, 16'd1, 1'b0};

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_toff", 64'(type_offset), 64'd0);
      chk("rst_wren", 64'(wren), 64'd0);
      chk("rst_cnt", 64'(commit_cnt), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table: offset write, one full rule, blocked offset write
      for (int i = 0; i < 11; i++) begin
         hdrive(tbl[i].hv, tbl[i].ha, tbl[i].hd, tbl[i].pb, 1'b0);
         chk($sformatf("tbl%0d_hready", i), 64'(host_ready), 64'(tbl[i].e_hr));
         chk($sformatf("tbl%0d_lready", i), 64'(ld_ready), 64'd0);
         chk($sformatf("tbl%0d_toff", i), 64'(type_offset), 64'(tbl[i].e_toff));
         chk($sformatf("tbl%0d_wren", i), 64'(wren), 64'(tbl[i].e_wren));
         chk($sformatf("tbl%0d_cnt", i), 64'(commit_cnt), 64'(tbl[i].e_cnt));
         chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
      end
      chk("rule1_data", 64'(type_data), 64'h0800_86DD);
      chk("rule1_mask", 64'(type_mask), 64'hFFFF_FFFF);
      chk("rule1_key", 64'(key_off), 64'h0605_0403_0201);
      chk("rule1_valid", 64'(rule_valid), 64'd1);

      // Commit stalled by pipe busy for 10 cycles
      host_rule(32'h8000_0002, 32'h0800_FFFF, 32'h86DD_FFFF, 32'h0403_0201, 32'h0000_0605);
      for (int i = 0; i < 10; i++) begin
         hdrive(1'b1, 32'd1, 32'd0, 1'b1, 1'b0);
         chk("stall_hready", 64'(host_ready), 64'd0);
         chk("stall_wren", 64'(wren), 64'd0);
      end
      hdrive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("stall_drop_wren", 64'(wren), 64'd0);
      hdrive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("stall_commit_wren", 64'(wren), 64'h4);
      chk("stall_commit_cnt", 64'(commit_cnt), 64'd2);
      hdrive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("wren_one_cycle", 64'(wren), 64'd0);

      // Out-of-range rule index
      host_rule(32'h8000_0007, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888);
      hdrive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("idx7_wren_a", 64'(wren), 64'd0);
      chk("idx7_busy", 64'(busy), 64'd1);
      hdrive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("idx7_wren_b", 64'(wren), 64'd0);
      chk("idx7_err", 64'(err), 64'd1);
      chk("idx7_cnt", 64'(commit_cnt), 64'd2);
      chk("idx7_data_hold", 64'(type_data), 64'h0800_86DD);

      // Error clear, then clear racing a new error (bad address)
      hdrive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      chk("clr_err_before", 64'(err), 64'd1);
      hdrive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("clr_err_after", 64'(err), 64'd0);
      hdrive(1'b1, 32'd9, 32'd0, 1'b0, 1'b1);
      chk("badaddr_ready", 64'(host_ready), 64'd1);
      hdrive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("err_beats_clr", 64'(err), 64'd1);

      // Reset in the middle of a rule
      hdrive(1'b1, 32'd1, 32'h8000_0001, 1'b0, 1'b0);
      hdrive(1'b1, 32'd1, 32'hAAAA_BBBB, 1'b0, 1'b0);
      hdrive(1'b1, 32'd1, 32'hCCCC_DDDD, 1'b0, 1'b0);
      chk("pre_rst_busy", 64'(busy), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      host_valid = 1'b0;
      #1;
      chk("mid_rst_toff", 64'(type_offset), 64'd0);
      chk("mid_rst_data", 64'(type_data), 64'd0);
      chk("mid_rst_mask", 64'(type_mask), 64'd0);
      chk("mid_rst_key", 64'(key_off), 64'd0);
      chk("mid_rst_valid", 64'(rule_valid), 64'd0);
      chk("mid_rst_cnt", 64'(commit_cnt), 64'd0);
      chk("mid_rst_err", 64'(err), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Arbitration from reset: host takes the tie and owns the whole rule
      drive(1'b1, 32'd1, 32'h8000_0000, 1'b1, 32'd1, 32'h8000_0001, 1'b0, 1'b0);
      chk("arb_tie_hready", 64'(host_ready), 64'd1);
      chk("arb_tie_lready", 64'(ld_ready), 64'd0);
      begin
         logic [31:0] hw[4];
         hw[0] = 32'h0800_FFFF; hw[1] = 32'h86DD_FFFF; hw[2] = 32'h0403_0201; hw[3] = 32'h0000_0605;
         for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'd1, hw[i], 1'b1, 32'd1, 32'h8000_0001, 1'b0, 1'b0);
            chk("arb_host_hready", 64'(host_ready), 64'd1);
            chk("arb_host_lready", 64'(ld_ready), 64'd0);
         end
      end
      drive(1'b1, 32'd1, 32'h8000_0003, 1'b1, 32'd1, 32'h8000_0001, 1'b0, 1'b0);
      chk("arb_commit_hready", 64'(host_ready), 64'd0);
      chk("arb_commit_lready", 64'(ld_ready), 64'd0);
      drive(1'b1, 32'd1, 32'h8000_0003, 1'b1, 32'd1, 32'h8000_0001, 1'b0, 1'b0);
      chk("arb_host_wren", 64'(wren), 64'h1);
      chk("arb_host_cnt", 64'(commit_cnt), 64'd1);
      chk("arb_next_lready", 64'(ld_ready), 64'd1);
      chk("arb_next_hready", 64'(host_ready), 64'd0);
      begin
         logic [31:0] lw[4];
         lw[0] = 32'h1111_2222; lw[1] = 32'h3333_4444; lw[2] = 32'hAAAA_5555; lw[3] = 32'h0000_0BBB;
         for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'd1, 32'h8000_0003, 1'b1, 32'd1, lw[i], 1'b0, 1'b0);
            chk("arb_ld_lready", 64'(ld_ready), 64'd1);
            chk("arb_ld_hready", 64'(host_ready), 64'd0);
         end
      end
      drive(1'b1, 32'd1, 32'h8000_0003, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("arb_ld_commit_hready", 64'(host_ready), 64'd0);
      drive(1'b1, 32'd1, 32'h8000_0003, 1'b1, 32'd1, 32'h8000_0001, 1'b0, 1'b0);
      chk("arb_ld_wren", 64'(wren), 64'h2);
      chk("arb_ld_cnt", 64'(commit_cnt), 64'd2);
      chk("arb_ld_data", 64'(type_data), 64'h1111_3333);
      chk("arb_ld_mask", 64'(type_mask), 64'h2222_4444);
      chk("arb_ld_key", 64'(key_off), 64'h0BBB_AAAA_5555);
      chk("arb_ld_valid", 64'(rule_valid), 64'd1);
      chk("arb_back_hready", 64'(host_ready), 64'd1);
      chk("arb_back_lready", 64'(ld_ready), 64'd0);
      drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
